// File: rtl/ptw_axi_arbiter_if.sv
// AXI read-channel bundle (AR + R) used for both walker ports and the
// interconnect port of ptw_axi_arbiter.
interface ptw_axi_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 10
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [ID_W-1:0]   rid;
  logic              rlast;

  // Side that issues read requests (walker, or the arbiter toward the interconnect)
  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rid, rlast
  );

  // Side that accepts read requests (arbiter toward a walker, or the interconnect)
  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rid, rlast
  );
endinterface

// File: rtl/ptw_axi_arbiter.sv
// Shares one AXI read channel between the I-MMU (s0) and D-MMU (s1)
// page-table walkers. Round-robin grant, one outstanding transaction,
// read beats routed back by the grant register (not by RID).
// Optional response watchdog enabled by defining PTW_ARB_TIMEOUT_EN.
module ptw_axi_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 10,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rstn,
  ptw_axi_arbiter_if.slave   s0,
  ptw_axi_arbiter_if.slave   s1,
  ptw_axi_arbiter_if.master  m,
  output logic               stray_r
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_e;

  state_e            state_q;
  logic              grant_q;
  logic              last_grant_q;
  logic              arvalid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [ID_W-1:0]   arid_q;
  logic [7:0]        arlen_q;
  logic [2:0]        arsize_q;
  logic [1:0]        arburst_q;

  logic              req_any;
  logic              grant_d;
  logic              in_r;
  logic              to_fire;
  logic              live;
  logic              rready_g;
  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic [1:0]        b_resp;
  logic [ID_W-1:0]   b_id;
  logic              b_last;
  logic              r_hs;
  logic              r_done;

  // Arbitration: sole requester wins; on a tie the walker that did not win last time
  always_comb begin
    req_any = s0.arvalid | s1.arvalid;
    grant_d = (s0.arvalid && s1.arvalid) ? ~last_grant_q : s1.arvalid;
    s0.arready = (state_q == S_IDLE) && req_any && !grant_d;
    s1.arready = (state_q == S_IDLE) && req_any &&  grant_d;
  end

  // Interconnect AR channel driven from the latched request
  always_comb begin
    m.arvalid = arvalid_q;
    m.araddr  = araddr_q;
    m.arid    = arid_q;
    m.arlen   = arlen_q;
    m.arsize  = arsize_q;
    m.arburst = arburst_q;
  end

`ifdef PTW_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q;

  // Response watchdog: cleared outside R and on each R handshake, saturates at TIMEOUT
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (state_q != S_R || r_hs) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_W'(TIMEOUT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Watchdog expiry substitutes a synthetic SLVERR beat for the interconnect
  always_comb to_fire = (state_q == S_R) && (cnt_q == CNT_W'(TIMEOUT));
`else
  // No watchdog: R waits for the interconnect indefinitely
  always_comb to_fire = 1'b0;
`endif

  // R-channel routing: beats go only to the granted walker; anything outside a live R phase is dropped
  always_comb begin
    in_r     = (state_q == S_R);
    live     = in_r && !to_fire;
    rready_g = grant_q ? s1.rready : s0.rready;
    b_valid  = live ? m.rvalid : to_fire;
    b_data   = live ? m.rdata  : '0;
    b_resp   = live ? m.rresp  : 2'b10;
    b_id     = live ? m.rid    : arid_q;
    b_last   = live ? m.rlast  : 1'b1;
    m.rready = live ? rready_g : 1'b1;
    stray_r  = m.rvalid && !live;
    r_hs     = live && m.rvalid && rready_g;
    r_done   = in_r && b_valid && rready_g && b_last;

    s0.rvalid = in_r && !grant_q && b_valid;
    s0.rdata  = (in_r && !grant_q) ? b_data : '0;
    s0.rresp  = (in_r && !grant_q) ? b_resp : '0;
    s0.rid    = (in_r && !grant_q) ? b_id   : '0;
    s0.rlast  = in_r && !grant_q && b_last;

    s1.rvalid = in_r && grant_q && b_valid;
    s1.rdata  = (in_r && grant_q) ? b_data : '0;
    s1.rresp  = (in_r && grant_q) ? b_resp : '0;
    s1.rid    = (in_r && grant_q) ? b_id   : '0;
    s1.rlast  = in_r && grant_q && b_last;
  end

  // Transaction FSM: IDLE grants and latches, AR presents the request, R waits for the last beat
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arid_q       <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            grant_q   <= grant_d;
            araddr_q  <= grant_d ? s1.araddr  : s0.araddr;
            arid_q    <= grant_d ? s1.arid    : s0.arid;
            arlen_q   <= grant_d ? s1.arlen   : s0.arlen;
            arsize_q  <= grant_d ? s1.arsize  : s0.arsize;
            arburst_q <= grant_d ? s1.arburst : s0.arburst;
            arvalid_q <= 1'b1;
            state_q   <= S_AR;
          end
        end
        S_AR: begin
          if (m.arready) begin
            arvalid_q <= 1'b0;
            state_q   <= S_R;
          end
        end
        S_R: begin
          if (r_done) begin
            last_grant_q <= grant_q;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ptw_axi_arbiter.sv
// Self-checking bench for ptw_axi_arbiter: directed scenarios followed by
// randomized request/beat traffic compared against a transaction-level model.
module tb_ptw_axi_arbiter;

  logic clk = 1'b0;
  logic rstn;
  logic stray_r;

  always #5 clk = ~clk;

  ptw_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(10)) s0_if ();
  ptw_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(10)) s1_if ();
  ptw_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(10)) m_if ();

  ptw_axi_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(10), .TIMEOUT(16)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s0      (s0_if),
    .s1      (s1_if),
    .m       (m_if),
    .stray_r (stray_r)
  );

  typedef struct {
    logic [31:0] a;
    logic [9:0]  id;
    logic [7:0]  len;
    logic [2:0]  sz;
    logic [1:0]  bu;
  } req_t;

  // Reference model state: pending requests and the previous winner
  req_t rq [2];
  bit   pend [2];
  bit   last_g;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [1:0]  s_rvalid;
  logic [1:0]  s_arready;
  logic [31:0] s_rdata [2];
  logic [1:0]  s_rresp [2];
  logic [9:0]  s_rid   [2];
  logic [1:0]  s_rlast;

  assign s_rvalid  = {s1_if.rvalid, s0_if.rvalid};
  assign s_arready = {s1_if.arready, s0_if.arready};
  assign s_rlast   = {s1_if.rlast, s0_if.rlast};
  assign s_rdata[0] = s0_if.rdata;
  assign s_rdata[1] = s1_if.rdata;
  assign s_rresp[0] = s0_if.rresp;
  assign s_rresp[1] = s1_if.rresp;
  assign s_rid[0]   = s0_if.rid;
  assign s_rid[1]   = s1_if.rid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ar(input int w, input bit v);
    if (w == 0) begin
      s0_if.arvalid = v; s0_if.araddr = rq[0].a; s0_if.arid = rq[0].id;
      s0_if.arlen = rq[0].len; s0_if.arsize = rq[0].sz; s0_if.arburst = rq[0].bu;
    end else begin
      s1_if.arvalid = v; s1_if.araddr = rq[1].a; s1_if.arid = rq[1].id;
      s1_if.arlen = rq[1].len; s1_if.arsize = rq[1].sz; s1_if.arburst = rq[1].bu;
    end
  endtask

  task automatic set_rready(input int w, input bit v);
    if (w == 0) s0_if.rready = v;
    else        s1_if.rready = v;
  endtask

  task automatic new_req(input int w, input logic [31:0] a, input logic [9:0] id,
                         input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
    rq[w] = '{a, id, len, sz, bu};
    pend[w] = 1'b1;
    drive_ar(w, 1'b1);
  endtask

  task automatic idle_inputs();
    s0_if.arvalid = 0; s1_if.arvalid = 0; s0_if.rready = 0; s1_if.rready = 0;
    s0_if.araddr = '0; s0_if.arid = '0; s0_if.arlen = '0; s0_if.arsize = '0; s0_if.arburst = '0;
    s1_if.araddr = '0; s1_if.arid = '0; s1_if.arlen = '0; s1_if.arsize = '0; s1_if.arburst = '0;
    m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = '0; m_if.rresp = '0; m_if.rid = '0; m_if.rlast = 0;
  endtask

  // Pulse reset for one cycle and check every output at its reset value
  task automatic do_reset(input string tag);
    @(negedge clk);
    rstn = 1'b0;
    idle_inputs();
    pend[0] = 0; pend[1] = 0;
    @(negedge clk);
    rstn = 1'b1;
    last_g = 1'b1;
    #1;
    chk({tag, "_arvalid"}, m_if.arvalid, 1'b0);
    chk({tag, "_arready"}, s_arready, 2'b00);
    chk({tag, "_rvalid"},  s_rvalid, 2'b00);
    chk({tag, "_stray"},   stray_r, 1'b0);
    chk({tag, "_fields"}, {m_if.araddr, m_if.arid, m_if.arlen, m_if.arsize, m_if.arburst}, '0);
  endtask

  // First IDLE cycle with requests pending: check the grant, then the AR presentation one cycle later
  task automatic grant_round(input string tag, output int g);
    g = (pend[0] && pend[1]) ? int'(!last_g) : (pend[1] ? 1 : 0);
    #1;
    chk({tag, "_arready"}, s_arready, (g == 1) ? 2'b10 : 2'b01);
    chk({tag, "_arvalid_c0"}, m_if.arvalid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    pend[g] = 1'b0;
    drive_ar(g, 1'b0);
    #1;
    chk({tag, "_arvalid_c1"}, m_if.arvalid, 1'b1);
    chk({tag, "_ar_fields"}, {m_if.araddr, m_if.arid, m_if.arlen, m_if.arsize, m_if.arburst},
        {rq[g].a, rq[g].id, rq[g].len, rq[g].sz, rq[g].bu});
    chk({tag, "_arready_busy"}, s_arready, 2'b00);
  endtask

  // Hold m_arready low for 'stall' cycles, then complete the AR handshake
  task automatic ar_phase(input string tag, input int g, input int stall);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      chk({tag, "_ar_hold"}, {m_if.arvalid, m_if.araddr, m_if.arid, m_if.arlen, m_if.arsize, m_if.arburst},
          {1'b1, rq[g].a, rq[g].id, rq[g].len, rq[g].sz, rq[g].bu});
    end
    m_if.arready = 1'b1;
    @(posedge clk);
    #1;
    m_if.arready = 1'b0;
  endtask

  // Deliver nbeats beats with random walker back-pressure; check routing of each beat
  task automatic r_phase(input string tag, input int g, input int nbeats,
                         input logic [1:0] resp_last, input logic [31:0] first_data);
    logic [31:0] d;
    logic [9:0]  id;
    logic [1:0]  rs;
    bit          lst;
    bit          rr;
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      d   = (b == 0) ? first_data : $urandom;
      id  = 10'($urandom);
      lst = (b == nbeats - 1);
      rs  = lst ? resp_last : 2'b00;
      m_if.rvalid = 1'b1; m_if.rdata = d; m_if.rresp = rs; m_if.rid = id; m_if.rlast = lst;
      for (int t = 0; t < 8; t++) begin
        rr = (t >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        set_rready(g, rr);
        set_rready(1 - g, 1'($urandom_range(0, 1)));
        #1;
        chk({tag, "_rvalid_route"}, s_rvalid, (g == 1) ? 2'b10 : 2'b01);
        chk({tag, "_rbeat"}, {s_rdata[g], s_rresp[g], s_rid[g], s_rlast[g]}, {d, rs, id, lst});
        chk({tag, "_m_rready"}, m_if.rready, rr);
        chk({tag, "_no_stray"}, stray_r, 1'b0);
        @(posedge clk);
        if (rr) break;
        @(negedge clk);
      end
      if (lst) last_g = g[0];
    end
    @(negedge clk);
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    s0_if.rready = 1'b0; s1_if.rready = 1'b0;
  endtask

  // A beat with nothing outstanding is dropped and flagged for exactly one cycle
  task automatic stray_check(input string tag);
    m_if.rvalid = 1'b1; m_if.rdata = $urandom; m_if.rlast = 1'b1; m_if.rresp = 2'b00;
    #1;
    chk({tag, "_stray"}, {stray_r, m_if.rready, s_rvalid}, {1'b1, 1'b1, 2'b00});
    @(posedge clk);
    @(negedge clk);
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    #1;
    chk({tag, "_stray_end"}, {stray_r, s_rvalid, m_if.arvalid}, {1'b0, 2'b00, 1'b0});
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int k;
    rstn = 1'b0;
    idle_inputs();

    // 1. single request with a 5-cycle AR stall
    do_reset("rst0");
    new_req(0, 32'h8000_1000, 10'h05, 8'd0, 3'd2, 2'b01);
    grant_round("t1", g);
    ar_phase("t1", g, 5);
    r_phase("t1", g, 1, 2'b00, 32'h1234_50CF);

    // 2. round-robin after reset
    do_reset("rst1");
    new_req(0, 32'h0000_1000, 10'h011, 8'd0, 3'd2, 2'b01);
    new_req(1, 32'h0000_2000, 10'h022, 8'd1, 3'd2, 2'b01);
    grant_round("t2a", g);
    chk("t2a_first_s0", g, 0);
    ar_phase("t2a", g, 0);
    r_phase("t2a", g, 1, 2'b00, 32'hA5A5_0001);
    grant_round("t2b", g);
    chk("t2b_second_s1", g, 1);
    ar_phase("t2b", g, 1);
    r_phase("t2b", g, 2, 2'b00, 32'hA5A5_0002);
    new_req(0, 32'h0000_3000, 10'h033, 8'd0, 3'd2, 2'b01);
    new_req(1, 32'h0000_4000, 10'h044, 8'd0, 3'd2, 2'b01);
    grant_round("t2c", g);
    chk("t2c_s0_again", g, 0);
    ar_phase("t2c", g, 0);
    r_phase("t2c", g, 1, 2'b00, 32'hA5A5_0003);
    grant_round("t2d", g);
    ar_phase("t2d", g, 0);

    // 3. error response forwarded; the next request is accepted immediately after
    r_phase("t3", g, 1, 2'b10, 32'hDEAD_0003);
    new_req(0, 32'h0000_5000, 10'h055, 8'd0, 3'd2, 2'b01);
    grant_round("t3_idle", g);
    ar_phase("t3", g, 0);
    r_phase("t3b", g, 1, 2'b00, 32'h0000_0005);

    // 4. stray beat in IDLE
    stray_check("t4");
    new_req(1, 32'h0000_6000, 10'h066, 8'd0, 3'd2, 2'b01);
    grant_round("t4_after", g);
    ar_phase("t4", g, 0);
    r_phase("t4", g, 1, 2'b00, 32'h0000_0006);

    // 5. reset while in R, then a fresh s1 request
    new_req(0, 32'h0000_7000, 10'h077, 8'd0, 3'd2, 2'b01);
    grant_round("t5", g);
    ar_phase("t5", g, 0);
    do_reset("t5_rst");
    new_req(1, 32'h0000_8000, 10'h088, 8'd0, 3'd2, 2'b01);
    grant_round("t5_new", g);
    chk("t5_new_s1", g, 1);
    ar_phase("t5_new", g, 2);
    r_phase("t5_new", g, 1, 2'b00, 32'h0000_0008);

`ifdef PTW_ARB_TIMEOUT_EN
    // 6. watchdog: no R beat after the AR handshake
    new_req(0, 32'h0000_9000, 10'h099, 8'd0, 3'd2, 2'b01);
    grant_round("t6", g);
    ar_phase("t6", g, 0);
    @(negedge clk);
    k = 0;
    while (!s0_if.rvalid && k < 100) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk("t6_latency", k, 16);
    chk("t6_beat", {s_rvalid, s_rdata[0], s_rresp[0], s_rid[0], s_rlast[0]},
        {2'b01, 32'h0, 2'b10, 10'h099, 1'b1});
    @(negedge clk);
    #1;
    chk("t6_held", {s_rvalid, s_rresp[0]}, {2'b01, 2'b10});
    s0_if.rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s0_if.rready = 1'b0;
    last_g = 1'b0;
    stray_check("t6_late");
`endif

    // Randomized traffic against the model
    do_reset("rst_rand");
    for (int r = 0; r < 40; r++) begin
      if (!pend[0] && !pend[1] && ($urandom_range(0, 3) == 0)) stray_check("rnd");
      for (int w = 0; w < 2; w++)
        if (!pend[w] && $urandom_range(0, 1) == 1)
          new_req(w, $urandom, 10'($urandom), 8'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 2'b01);
      if (!pend[0] && !pend[1]) begin
        k = $urandom_range(0, 1);
        new_req(k, $urandom, 10'($urandom), 8'd0, 3'd2, 2'b01);
      end
      grant_round("rnd", g);
      ar_phase("rnd", g, $urandom_range(0, 3));
      r_phase("rnd", g, $urandom_range(1, 4), ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
